// File: rtl/serial_subtract_controller.sv
// Bit-serial subtractor: computes minuend - subtrahend LSB first over WIDTH cycles
// through a single full-subtractor cell. Optional macro SATURATE_EN clamps underflow to 0.
`timescale 1ns/1ps

module serial_full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);
  assign diff_o = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module serial_subtract_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, difference_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, borrow_out_q, busy_q, done_q;

  logic             fs_diff, fs_bout;
  logic [WIDTH-1:0] res_d, diff_d;
  logic             last_bit;

  serial_full_subtractor u_fs (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .bin_i (borrow_q),
    .diff_o(fs_diff),
    .bout_o(fs_bout)
  );

  // New diff bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  assign res_d    = {fs_diff, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SATURATE_EN
  assign diff_d = fs_bout ? '0 : res_d;
`else
  assign diff_d = res_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      difference_q <= '0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= minuend;
            b_q      <= subtrahend;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          res_q    <= res_d;
          borrow_q <= fs_bout;
          if (last_bit) begin
            difference_q <= diff_d;
            borrow_out_q <= fs_bout;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign difference = difference_q;
  assign borrow_out = borrow_out_q;
endmodule
